// File: rtl/table_ad_receive.sv
// -----------------------------------------------------------------------------
// table_ad_receive
//
// Per-channel receiver for the byte-serial table address/data bus. While this
// channel's enable (dv) is high, one byte per cycle arrives LSB first:
//   - a 3-byte burst with a_not_d=1 on its first byte loads the table address
//   - a 4-byte burst with a_not_d=0 on its first byte carries one 32-bit data
//     word, unpacked into 32/DATA_WIDTH table writes at consecutive addresses
// The address auto-increments after every write and wraps silently.
//
// Parameters
//   ADDR_BITS   table address width (1..24); low bits of the 24-bit burst address
//   DATA_WIDTH  table word width: 8, 16 or 32
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   srst     in   synchronous active-high reset
//   a_not_d  in   burst type, sampled with the first byte only
//   ser_d    in   serial byte, valid while dv=1
//   dv       in   channel enable, one byte per cycle while high
//   taddr    out  table write address, valid with twe
//   tdata    out  table write data, valid with twe
//   twe      out  single-cycle write strobe per table word
//   err      out  single-cycle pulse on a truncated or over-long burst
// -----------------------------------------------------------------------------
module table_ad_receive #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  a_not_d,
    input  logic [7:0]            ser_d,
    input  logic                  dv,
    output logic [ADDR_BITS-1:0]  taddr,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  twe,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    // True when byte k (0..3) of a data burst is the last byte of a table word.
    function automatic logic word_complete(input logic [1:0] k);
        logic done;
        if (DATA_WIDTH == 8) begin
            done = 1'b1;
        end else if (DATA_WIDTH == 16) begin
            done = k[0];
        end else begin
            done = (k == 2'd3);
        end
        return done;
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [31:0]             buf_q, buf_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [ADDR_BITS-1:0]    taddr_q, taddr_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    twe_q, twe_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;   // over-long error already reported for this burst

    logic [1:0]              byte_idx_s;
    logic [31:0]             assembled_s;
    logic [5:0]              word_lo_s;
    logic [DATA_WIDTH-1:0]   word_s;
    logic                    issue_s;

    // Assemble the word ending at the current byte: earlier bytes from the
    // buffer, the current byte straight from the bus.
    always_comb begin
        if (state_q == S_DATA) begin
            byte_idx_s = cnt_q;
        end else begin
            byte_idx_s = 2'd0;
        end
        assembled_s = buf_q;
        assembled_s[{byte_idx_s, 3'b000} +: 8] = ser_d;
        // Bit offset of the word's LSB; only meaningful when the word completes.
        word_lo_s = {1'b0, byte_idx_s, 3'b000} + 6'd8 - 6'(DATA_WIDTH);
        word_s    = DATA_WIDTH'(assembled_s >> word_lo_s);
    end

    // Next-state and output logic of the burst receiver.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        taddr_d = taddr_q;
        tdata_d = tdata_q;
        twe_d   = 1'b0;
        err_d   = 1'b0;
        ovf_d   = ovf_q;
        issue_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dv) begin
                    buf_d[7:0] = ser_d;
                    cnt_d      = 2'd1;
                    if (a_not_d) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DATA;
                        issue_s = word_complete(2'd0);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (dv) begin
                    if (cnt_q == 2'd2) begin
                        // Upper burst-address bits beyond ADDR_BITS are dropped.
                        addr_d  = ADDR_BITS'({ser_d, buf_q[15:0]});
                        cnt_d   = 2'd0;
                        ovf_d   = 1'b0;
                        state_d = S_SKIP;
                    end else begin
                        buf_d[{cnt_q, 3'b000} +: 8] = ser_d;
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    // Truncated address burst: address register left untouched.
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (dv) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = ser_d;
                    issue_s = word_complete(cnt_q);
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        ovf_d   = 1'b0;
                        state_d = S_SKIP;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    // Truncated data burst: the partial word is simply dropped.
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            S_SKIP: begin
                if (dv) begin
                    // Extra bytes are ignored; flag only the first one.
                    if (!ovf_q) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                end else begin
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = 2'd0;
                state_d = S_IDLE;
            end
        endcase

        // A completed word is written at the current address, which then
        // advances so the next word of the burst lands one entry higher.
        if (issue_s) begin
            twe_d   = 1'b1;
            taddr_d = addr_q;
            tdata_d = word_s;
            addr_d  = addr_q + ADDR_BITS'(1'b1);
        end else begin
            twe_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
            addr_q  <= {ADDR_BITS{1'b0}};
            taddr_q <= {ADDR_BITS{1'b0}};
            tdata_q <= {DATA_WIDTH{1'b0}};
            twe_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            taddr_q <= taddr_d;
            tdata_q <= tdata_d;
            twe_q   <= twe_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // srst forces the outputs to their reset values in the cycle it is
    // asserted, so a write already queued in twe_q never reaches the table.
    assign twe   = twe_q & ~srst;
    assign err   = err_q & ~srst;
    assign taddr = srst ? {ADDR_BITS{1'b0}} : taddr_q;
    assign tdata = srst ? {DATA_WIDTH{1'b0}} : tdata_q;

endmodule

// File: tb/tb_table_ad_receive.sv
// Bench for table_ad_receive: three instances (32-, 8- and 16-bit table words,
// 8-bit address) share one serial bus. A burst table drives the bus; a small
// model pushes the expected writes (cycle, address, data) and error cycles into
// queues, and a negedge monitor pops and compares them cycle by cycle.
module tb_table_ad_receive;

    logic        clk = 1'b0;
    logic        srst;
    logic        a_not_d;
    logic        dv;
    logic [7:0]  ser_d;

    logic [7:0]  taddr32, taddr8, taddr16;
    logic [31:0] tdata32;
    logic [7:0]  tdata8;
    logic [15:0] tdata16;
    logic        twe32, twe8, twe16;
    logic        err32, err8, err16;

    always #5 clk = ~clk;

    table_ad_receive #(.ADDR_BITS(8), .DATA_WIDTH(32)) u_dut32 (
        .clk(clk), .srst(srst), .a_not_d(a_not_d), .ser_d(ser_d), .dv(dv),
        .taddr(taddr32), .tdata(tdata32), .twe(twe32), .err(err32));
    table_ad_receive #(.ADDR_BITS(8), .DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .srst(srst), .a_not_d(a_not_d), .ser_d(ser_d), .dv(dv),
        .taddr(taddr8), .tdata(tdata8), .twe(twe8), .err(err8));
    table_ad_receive #(.ADDR_BITS(8), .DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .srst(srst), .a_not_d(a_not_d), .ser_d(ser_d), .dv(dv),
        .taddr(taddr16), .tdata(tdata16), .twe(twe16), .err(err16));

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        a;
        int          len;
        logic [31:0] val;
        int          gap;
        logic        exp_err;
    } burst_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t q2[$];
    int  eq[$];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [7:0] ea[3];
    int         dwv[3] = '{32, 8, 16};
    burst_t     tbl[18];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int d, input int c, input logic [7:0] a, input logic [31:0] v);
        wr_t e;
        e.cyc = c; e.addr = a; e.data = v;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Expected writes of a data burst starting at edge 'start'; only words whose
    // last byte index is below 'lim' are written.
    task automatic expect_data(input int start, input int lim, input logic [31:0] val);
        for (int d = 0; d < 3; d++) begin
            int bpw;
            logic [31:0] mask;
            bpw  = dwv[d] / 8;
            mask = (dwv[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dwv[d]) - 32'd1);
            for (int w = 0; w < 4 / bpw; w++) begin
                int last;
                last = (w + 1) * bpw - 1;
                if (last < lim) begin
                    push_wr(d, start + last, ea[d], (val >> (w * dwv[d])) & mask);
                    ea[d] = ea[d] + 8'd1;
                end
            end
        end
    endtask

    task automatic drive_bytes(input logic a, input int len, input logic [31:0] val);
        logic [31:0] vb;
        vb = val;
        for (int i = 0; i < len; i++) begin
            dv = 1'b1;
            a_not_d = (i == 0) ? a : ~a;   // later changes must be ignored
            ser_d = (i < 4) ? vb[8*i +: 8] : 8'($urandom);
            tick();
        end
        dv = 1'b0;
        a_not_d = 1'($urandom);
        ser_d = 8'($urandom);
    endtask

    task automatic run_burst(input burst_t b);
        int start;
        int full;
        start = cyc + 1;
        full  = b.a ? 3 : 4;
        if (b.a) begin
            if (b.len >= 3) begin
                for (int d = 0; d < 3; d++) ea[d] = b.val[7:0];
            end
        end else begin
            expect_data(start, b.len, b.val);
        end
        if (b.exp_err) eq.push_back((b.len < full) ? start + b.len : start + full);
        drive_bytes(b.a, b.len, b.val);
        repeat (b.gap) tick();
    endtask

    task automatic check_out(input int d, input logic t, input logic [7:0] a, input logic [31:0] dat);
        wr_t e;
        logic has;
        has = 1'b0;
        case (d)
            0: begin
                while (q0.size() > 0 && q0[0].cyc < cyc) begin
                    e = q0.pop_front(); checks++; errors++;
                    $display("FAIL missed_write dut0 cyc %0d: got none want addr %h", e.cyc, e.addr);
                end
                if (q0.size() > 0 && q0[0].cyc == cyc) begin has = 1'b1; e = q0.pop_front(); end
            end
            1: begin
                while (q1.size() > 0 && q1[0].cyc < cyc) begin
                    e = q1.pop_front(); checks++; errors++;
                    $display("FAIL missed_write dut1 cyc %0d: got none want addr %h", e.cyc, e.addr);
                end
                if (q1.size() > 0 && q1[0].cyc == cyc) begin has = 1'b1; e = q1.pop_front(); end
            end
            default: begin
                while (q2.size() > 0 && q2[0].cyc < cyc) begin
                    e = q2.pop_front(); checks++; errors++;
                    $display("FAIL missed_write dut2 cyc %0d: got none want addr %h", e.cyc, e.addr);
                end
                if (q2.size() > 0 && q2[0].cyc == cyc) begin has = 1'b1; e = q2.pop_front(); end
            end
        endcase
        checks++;
        if (t !== has) begin
            errors++;
            $display("FAIL twe dut%0d cyc %0d: got %b want %b", d, cyc, t, has);
        end
        if (has && t === 1'b1) begin
            checks++;
            if (a !== e.addr || dat !== e.data) begin
                errors++;
                $display("FAIL write dut%0d cyc %0d: got (%h,%h) want (%h,%h)",
                         d, cyc, a, dat, e.addr, e.data);
            end
        end
    endtask

    // Cycle-by-cycle scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_e;
            check_out(0, twe32, taddr32, tdata32);
            check_out(1, twe8,  taddr8,  {24'd0, tdata8});
            check_out(2, twe16, taddr16, {16'd0, tdata16});
            exp_e = (eq.size() > 0 && eq[0] == cyc);
            checks++;
            if ({err32, err8, err16} !== {3{exp_e}}) begin
                errors++;
                $display("FAIL err cyc %0d: got %b%b%b want %b", cyc, err32, err8, err16, exp_e);
            end
            if (exp_e) void'(eq.pop_front());
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({twe32, twe8, twe16, err32, err8, err16} !== 6'd0 ||
            {taddr32, taddr8, taddr16} !== 24'd0 ||
            {tdata32, tdata8, tdata16} !== 56'd0) begin
            errors++;
            $display("FAIL %s: got twe %b%b%b err %b%b%b taddr %h/%h/%h tdata %h/%h/%h want all zero",
                     name, twe32, twe8, twe16, err32, err8, err16,
                     taddr32, taddr8, taddr16, tdata32, tdata8, tdata16);
        end
    endtask

    initial begin
        //        a     len  value          gap exp_err
        tbl[0]  = '{1'b1, 3, 32'h0000_0012, 1, 1'b0};
        tbl[1]  = '{1'b0, 4, 32'hDEAD_BEEF, 2, 1'b0};
        tbl[2]  = '{1'b0, 4, 32'h0BAD_F00D, 1, 1'b0};
        tbl[3]  = '{1'b1, 3, 32'h0000_00FE, 1, 1'b0};
        tbl[4]  = '{1'b0, 4, 32'h4433_2211, 1, 1'b0};
        tbl[5]  = '{1'b1, 3, 32'h00AB_0005, 1, 1'b0};
        tbl[6]  = '{1'b0, 4, 32'hAAAA_5555, 3, 1'b0};
        tbl[7]  = '{1'b1, 2, 32'h0000_0077, 1, 1'b1};
        tbl[8]  = '{1'b0, 4, 32'h1234_5678, 1, 1'b0};
        tbl[9]  = '{1'b0, 6, 32'hCAFE_F00D, 1, 1'b1};
        tbl[10] = '{1'b0, 4, 32'h0102_0304, 2, 1'b0};
        tbl[11] = '{1'b0, 2, 32'h0000_BEEF, 1, 1'b1};
        tbl[12] = '{1'b1, 1, 32'h0000_0033, 1, 1'b1};
        tbl[13] = '{1'b0, 4, 32'h89AB_CDEF, 1, 1'b0};
        tbl[14] = '{1'b1, 3, 32'h0000_00FF, 1, 1'b0};
        tbl[15] = '{1'b0, 4, 32'h5566_7788, 1, 1'b0};
        tbl[16] = '{1'b1, 5, 32'h0000_0040, 1, 1'b1};
        tbl[17] = '{1'b0, 4, 32'h1111_2222, 2, 1'b0};

        for (int d = 0; d < 3; d++) ea[d] = 8'h00;
        srst = 1'b1; dv = 1'b0; a_not_d = 1'b0; ser_d = 8'h00;
        tick(); tick();
        srst = 1'b0;
        tick();
        check_zero("reset_state");
        mon_en = 1'b1;

        // Data burst before any address burst writes from address 0.
        run_burst('{1'b0, 4, 32'h7766_5544, 1, 1'b0});

        for (int i = 0; i < 18; i++) run_burst(tbl[i]);

        // srst in the cycle after byte 3 of a data burst drops the final write.
        begin
            int start;
            start = cyc + 1;
            expect_data(start, 3, 32'h9988_7766);
            drive_bytes(1'b0, 4, 32'h9988_7766);
            srst = 1'b1;
            #1;
            check_zero("srst_drop_twe");
            tick();
            srst = 1'b0;
            for (int d = 0; d < 3; d++) ea[d] = 8'h00;
            #1;
            check_zero("after_srst");
            tick();
        end
        run_burst('{1'b0, 4, 32'hFEDC_BA98, 3, 1'b0});

        repeat (4) tick();
        mon_en = 1'b0;
        checks++;
        if (q0.size() + q1.size() + q2.size() + eq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending events want 0",
                     q0.size() + q1.size() + q2.size() + eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
